imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the word-addressed, combinational-read instruction memory. It owns the program counter and drives the word address. Each fetched word is captured with its PC into a 2-entry instruction queue, which presents instructions to decode over a valid/ready handshake. It also handles the post-reset boot wait, branch/jump redirects with queue flush, halt requests, and out-of-range/misaligned-PC faults.

Parameters:
WIDTH, 32, data/PC width in bits (matches `WIDTH)
IMEM_LEN, 256, instruction memory size in bytes; legal PCs are 0..IMEM_LEN-4
RESET_PC, 0, PC after reset (word aligned)
BOOT_CYCLES, 4, cycles to wait after reset release before the first fetch (memory load time)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
imem_add  out  WIDTH-2  word address to instruction memory, equal to pc[WIDTH-1:2]
imem_data  in  WIDTH  instruction word returned combinationally for imem_add
redirect_valid  in  1  load a new PC and flush the queue
redirect_pc  in  WIDTH  target byte PC
inst_valid  out  1  queue head is valid
inst_ready  in  1  decode accepts head this cycle
inst  out  WIDTH  queue head instruction
inst_pc  out  WIDTH  byte PC of queue head
halt_req  in  1  stop fetching
halted  out  1  state == HALT
fault  out  1  sticky fault flag

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC; state=BOOT; boot counter=0; queue count=0.
  Outputs: inst_valid=0, inst=0, inst_pc=0, halted=0, fault=0, imem_add=RESET_PC>>2.
- imem_add is always pc[WIDTH-1:2], driven combinationally from the pc register.
- States:
  - BOOT: counter increments each cycle and no fetch occurs. When counter==BOOT_CYCLES-1, go to RUN. A redirect in BOOT updates pc only (same alignment/range checks) and the state stays BOOT.
  - RUN: normal fetching.
  - HALT: no fetch occurs. The queue keeps draining to decode.
- pop = inst_valid & inst_ready. The head advances and count decrements.
- fetch = RUN & !redirect_valid & !halt_req & (count<2 | pop) & (pc <= IMEM_LEN-4).
  - On fetch, enqueue {imem_data, pc} at the tail and set pc <= pc+4.
  - Fetch and pop in the same cycle leave count unchanged.
  - Throughput is 1 instruction/cycle.
  - Latency: a word is visible on inst the cycle after the edge that fetched it.
- Range fault: RUN & !redirect_valid & !halt_req & pc > IMEM_LEN-4 → fault=1, state=HALT, no enqueue, pc held.
- Redirect (any state except fault-HALT):
  - queue flushed (count=0) at the edge. A simultaneous pop is still a completed handshake for decode.
  - pc <= redirect_pc.
  - No fetch that cycle.
  - Misaligned target (redirect_pc[1:0]!=0) or target > IMEM_LEN-4: fault=1, state=HALT, pc unchanged.
  - Otherwise, from HALT (non-fault) the state returns to RUN. First fetch of the target occurs the following cycle.
- Priority within a cycle: reset > redirect > halt_req > fetch.
- halt_req in RUN (no redirect): state=HALT next edge, no fetch that cycle. Queue contents are retained and drain normally.
- fault is sticky. Once set, only rst_n clears it, and redirects are ignored.
- Reset mid-operation: queue contents discarded immediately. Outputs return to reset values asynchronously.
- Queue: 2 entries, circular read/write pointers.
  - count never exceeds 2.
  - With count==2 and no pop, no fetch occurs and pc is held.

Test Plan:
- Boot: release rst_n with BOOT_CYCLES=4 and memory words 0x11,0x22,0x33 at 0,4,8; hold inst_ready=1 → imem_add=0 for 4 cycles. Then inst=0x11/pc 0, 0x22/pc 4, 0x33/pc 8 on consecutive cycles with inst_valid=1.
- Backpressure: inst_ready=0 after boot → count fills to 2 with pc 0 and pc 4, pc holds at 8, and inst stays 0x11. Raise inst_ready → 0x11, 0x22, 0x33 delivered in order with no duplicate or drop.
- Redirect flush: queue holding pc 0/4, assert redirect_valid with redirect_pc=0x40 for one cycle → inst_valid=0 next cycle. The cycle after, inst_pc=0x40 with inst=mem[0x40].
- Halt/resume: halt_req=1 for one cycle in RUN → halted=1, queue drains, and no further imem_add change. Then redirect to 0x10 → halted=0 and the next inst_pc=0x10.
- Faults: redirect_pc=0x42 → fault=1, halted=1, and a later redirect to 0x0 is ignored. After reset, sequential fetch up to pc=IMEM_LEN-4=0xFC → next cycle fault=1, with the last queued inst_pc=0xFC.
- Async reset mid-run: drop rst_n with count=2 between clock edges → inst_valid=0, fault=0, and imem_add=RESET_PC>>2 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction-fetch sequencer for a word-addressed instruction memory with
//   combinational read. Owns the program counter and presents fetched words,
//   each tagged with its byte PC, to decode through a 2-entry queue with a
//   valid/ready handshake. Also provides a post-reset boot wait, redirects
//   with queue flush, halt requests, and a sticky range/alignment fault.
//
// Ports:
//   clk            in   clock, all state updates on posedge
//   rst_n          in   asynchronous active-low reset
//   imem_add       out  word address to instruction memory (pc[WIDTH-1:2])
//   imem_data      in   instruction word returned combinationally for imem_add
//   redirect_valid in   load redirect_pc and flush the queue
//   redirect_pc    in   target byte PC
//   inst_valid     out  queue head is valid
//   inst_ready     in   decode accepts the head this cycle
//   inst           out  queue head instruction (0 when queue is empty)
//   inst_pc        out  byte PC of queue head (0 when queue is empty)
//   halt_req       in   stop fetching
//   halted         out  controller is in HALT
//   fault          out  sticky fault flag, cleared only by rst_n
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int WIDTH       = 32,
  parameter int IMEM_LEN    = 256,
  parameter int RESET_PC    = 0,
  parameter int BOOT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-3:0] imem_add,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             halt_req,
  output logic             halted,
  output logic             fault
);

  localparam logic [WIDTH-1:0] LAST_PC   = WIDTH'(IMEM_LEN - 4);
  localparam logic [WIDTH-1:0] RST_PC    = WIDTH'(RESET_PC);
  localparam int               BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0]    BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // A redirect target is usable only if word aligned and inside memory.
  function automatic logic target_legal(input logic [WIDTH-1:0] p);
    return (p[1:0] == 2'b00) && (p <= LAST_PC);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic             fault_q, fault_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic [WIDTH-1:0] epc_q  [2];
  logic [WIDTH-1:0] epc_d  [2];

  logic fetch;
  logic flush;
  logic pop;

  assign pop = (count_q != 2'd0) && inst_ready;

  // Sequencer: state, PC, boot counter and fault; decides fetch and flush.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    fault_d    = fault_q;
    fetch      = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // The counter keeps running through a BOOT redirect; only the PC moves.
        boot_cnt_d = boot_cnt_q + BW'(1);
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BOOT;
        end
        if (redirect_valid) begin
          flush = 1'b1;
          if (target_legal(redirect_pc)) begin
            pc_d = redirect_pc;
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (target_legal(redirect_pc)) begin
            pc_d = redirect_pc;
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (pc_q > LAST_PC) begin
          // Sequential fetch ran off the end of memory.
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else if ((count_q < 2'd2) || pop) begin
          fetch = 1'b1;
          pc_d  = pc_q + WIDTH'(4);
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HALT: begin
        // Once faulted, only rst_n can restart the controller.
        if (redirect_valid && !fault_q) begin
          flush = 1'b1;
          if (target_legal(redirect_pc)) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
          end else begin
            fault_d = 1'b1;
          end
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  // Queue bookkeeping: flush wins over push/pop; push writes at the tail.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    epc_d    = epc_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (fetch) begin
        data_d[wr_ptr_q] = imem_data;
        epc_d[wr_ptr_q]  = pc_q;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + {1'b0, fetch} - {1'b0, pop};
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RST_PC;
      boot_cnt_q <= '0;
      fault_q    <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        epc_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      data_q     <= data_d;
      epc_q      <= epc_d;
    end
  end

  assign imem_add   = pc_q[WIDTH-1:2];
  assign inst_valid = (count_q != 2'd0);
  // Head fields are forced to zero when empty so stale entries never show.
  assign inst       = inst_valid ? data_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? epc_q[rd_ptr_q]  : '0;
  assign halted     = (state_q == ST_HALT);
  assign fault      = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Directed bench for imem_fetch_ctrl with a behavioural combinational
//   instruction memory (words 0x11/0x22/0x33 at 0/4/8, else 0xA0000000|pc).
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] imem_add;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halt_req;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign imem_data = mem[imem_add[5:0]];

  imem_fetch_ctrl #(
    .WIDTH(32), .IMEM_LEN(256), .RESET_PC(0), .BOOT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_add(imem_add), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .halt_req(halt_req), .halted(halted), .fault(fault)
  );

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h11;
    else if (pc == 32'h4) return 32'h22;
    else if (pc == 32'h8) return 32'h33;
    else return 32'hA000_0000 | pc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    halt_req = 1'b0; inst_ready = 1'b1;
    #2;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
        halted !== 1'b0 || fault !== 1'b0 || imem_add !== 30'h0) begin
      errors++;
      $display("FAIL reset: valid=%0b inst=%0h pc=%0h halted=%0b fault=%0b add=%0h, expected all 0",
               inst_valid, inst, inst_pc, halted, fault, imem_add);
    end
  endtask

  task automatic test_boot();
    inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (imem_add !== 30'h0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL boot_wait[%0d]: add=%0h valid=%0b, expected 0/0", i, imem_add, inst_valid);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst !== exp_word(32'(i * 4)) || inst_pc !== 32'(i * 4)) begin
        errors++;
        $display("FAIL boot_fetch[%0d]: valid=%0b inst=%0h pc=%0h, expected 1/%0h/%0h",
                 i, inst_valid, inst, inst_pc, exp_word(32'(i * 4)), i * 4);
      end
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    do_reset();
    repeat (4) step();
    repeat (3) step();  // two fetches fill the queue, third cycle stalls
    checks++;
    if (imem_add !== 30'h2 || inst_valid !== 1'b1 || inst !== 32'h11 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_full: add=%0h valid=%0b inst=%0h pc=%0h, expected 2/1/11/0",
               imem_add, inst_valid, inst, inst_pc);
    end
    inst_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst !== exp_word(32'(i * 4)) || inst_pc !== 32'(i * 4)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: valid=%0b inst=%0h pc=%0h, expected 1/%0h/%0h",
                 i, inst_valid, inst, inst_pc, exp_word(32'(i * 4)), i * 4);
      end
    end
  endtask

  // Redirect flush followed by halt/resume and the misaligned-target fault.
  task automatic test_redirect_halt_fault();
    inst_ready = 1'b0;
    do_reset();
    repeat (4) step();
    repeat (2) step();  // queue holds pc 0 and pc 4
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_add !== 30'h10) begin
      errors++;
      $display("FAIL redir_flush: valid=%0b add=%0h, expected 0/10", inst_valid, imem_add);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== exp_word(32'h40)) begin
      errors++;
      $display("FAIL redir_target: valid=%0b pc=%0h inst=%0h, expected 1/40/%0h",
               inst_valid, inst_pc, inst, exp_word(32'h40));
    end
    step();  // fetch 0x44 too, queue now full, pc=0x48
    halt_req = 1'b1; inst_ready = 1'b1;
    step();
    halt_req = 1'b0;
    checks++;
    if (halted !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 32'h44 || imem_add !== 30'h12) begin
      errors++;
      $display("FAIL halt_enter: halted=%0b valid=%0b pc=%0h add=%0h, expected 1/1/44/12",
               halted, inst_valid, inst_pc, imem_add);
    end
    step();
    step();
    checks++;
    if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_add !== 30'h12) begin
      errors++;
      $display("FAIL halt_drain: halted=%0b valid=%0b add=%0h, expected 1/0/12",
               halted, inst_valid, imem_add);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || inst_valid !== 1'b0 || imem_add !== 30'h4) begin
      errors++;
      $display("FAIL resume: halted=%0b valid=%0b add=%0h, expected 0/0/4", halted, inst_valid, imem_add);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== exp_word(32'h10)) begin
      errors++;
      $display("FAIL resume_fetch: valid=%0b pc=%0h inst=%0h, expected 1/10/%0h",
               inst_valid, inst_pc, inst, exp_word(32'h10));
    end
    // pc is now 0x14; misaligned target must fault and leave pc alone.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0 || imem_add !== 30'h5) begin
      errors++;
      $display("FAIL misalign: fault=%0b halted=%0b valid=%0b add=%0h, expected 1/1/0/5",
               fault, halted, inst_valid, imem_add);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0 || imem_add !== 30'h5) begin
      errors++;
      $display("FAIL fault_sticky: fault=%0b halted=%0b valid=%0b add=%0h, expected 1/1/0/5",
               fault, halted, inst_valid, imem_add);
    end
  endtask

  task automatic test_range_fault();
    inst_ready = 1'b1;
    do_reset();
    repeat (4) step();
    for (int k = 0; k < 64; k++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(k * 4) || inst !== exp_word(32'(k * 4)) ||
          fault !== 1'b0) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: valid=%0b pc=%0h inst=%0h fault=%0b, expected 1/%0h/%0h/0",
                 k, inst_valid, inst_pc, inst, fault, k * 4, exp_word(32'(k * 4)));
      end
    end
    step();
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0 || imem_add !== 30'h40) begin
      errors++;
      $display("FAIL range_fault: fault=%0b halted=%0b valid=%0b add=%0h, expected 1/1/0/40",
               fault, halted, inst_valid, imem_add);
    end
  endtask

  task automatic test_async_reset();
    inst_ready = 1'b0;
    do_reset();
    repeat (4) step();
    repeat (2) step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_add !== 30'h2) begin
      errors++;
      $display("FAIL pre_async: valid=%0b pc=%0h add=%0h, expected 1/0/2", inst_valid, inst_pc, imem_add);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || fault !== 1'b0 || halted !== 1'b0 || imem_add !== 30'h0 ||
        inst !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b fault=%0b halted=%0b add=%0h inst=%0h, expected 0/0/0/0/0",
               inst_valid, fault, halted, imem_add, inst);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = exp_word(32'(i * 4));
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_halt_fault();
    test_range_fault();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
